// File: rtl/io_pkg.sv
// Shared types and constants for the serial transmit peripheral.
// IO_SERIAL_TX_PARITY_EN adds the PARITY state to the FSM encoding.
package io_pkg;

    localparam int CLKS_PER_BIT_DEF = 16;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

`ifdef IO_SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;
`endif

endpackage

// File: rtl/io_fifo.sv
// Small byte FIFO with registered count/full/empty and a combinational head read.
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    // A push into a full FIFO is allowed only when the head leaves in the same cycle.
    always_comb begin
        do_push = push_i & (~full_q | pop_i);
        do_pop  = pop_i & ~empty_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/io_serial_tx.sv
// Queued asynchronous serial transmitter: start, 8 data bits LSB first, stop.
// IO_SERIAL_TX_PARITY_EN inserts an even-parity bit between data and stop.
module io_serial_tx
    import io_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_stb,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_ovf,
    output logic             tx,
    output logic             busy,
    output logic             full,
    output logic             empty,
    output logic [7:0]       status
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DEPTH) + 1;

    tx_state_t        state_q;
    logic [BW-1:0]    baud_q;
    logic [2:0]       bit_q;
    logic [WIDTH-1:0] shift_q;
    logic             tx_q, busy_q, ovf_q, ovf_d;
`ifdef IO_SERIAL_TX_PARITY_EN
    logic             parity_q;
`endif

    logic [WIDTH-1:0] fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full, fifo_empty;
    logic             baud_end, pop;
    logic [2:0]       cnt3;

    io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_stb),
        .pop_i   (pop),
        .din_i   (wr_data),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Popping at the end of STOP lets the next start bit follow with no idle gap.
    always_comb begin
        baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));
        pop      = ~fifo_empty & ((state_q == S_IDLE) | ((state_q == S_STOP) & baud_end));
        ovf_d    = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (wr_stb & fifo_full & ~pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef IO_SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            ovf_q <= ovf_d;
            if (pop) begin
`ifdef IO_SERIAL_TX_PARITY_EN
                parity_q <= ^fifo_dout;
`endif
            end
            case (state_q)
                S_IDLE: if (pop) begin
                    shift_q <= fifo_dout;
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b1;
                    baud_q  <= '0;
                    state_q <= S_START;
                end
                S_START: if (baud_end) begin
                    baud_q  <= '0;
                    bit_q   <= '0;
                    tx_q    <= shift_q[0];
                    state_q <= S_DATA;
                end else baud_q <= baud_q + 1'b1;
                S_DATA: if (baud_end) begin
                    baud_q <= '0;
                    if (bit_q == 3'd7) begin
`ifdef IO_SERIAL_TX_PARITY_EN
                        tx_q    <= parity_q;
                        state_q <= S_PARITY;
`else
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
`endif
                    end else begin
                        shift_q <= shift_q >> 1;
                        tx_q    <= shift_q[1];
                        bit_q   <= bit_q + 3'd1;
                    end
                end else baud_q <= baud_q + 1'b1;
`ifdef IO_SERIAL_TX_PARITY_EN
                S_PARITY: if (baud_end) begin
                    baud_q  <= '0;
                    tx_q    <= 1'b1;
                    state_q <= S_STOP;
                end else baud_q <= baud_q + 1'b1;
`endif
                S_STOP: if (baud_end) begin
                    baud_q <= '0;
                    if (pop) begin
                        shift_q <= fifo_dout;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end else baud_q <= baud_q + 1'b1;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    generate
        if (CW >= 3) begin : g_cnt
            assign cnt3 = fifo_count[2:0];
        end else begin : g_cnt_pad
            assign cnt3 = {{(3 - CW){1'b0}}, fifo_count};
        end
    endgenerate

    always_comb begin
        status                   = '0;
        status[ST_EMPTY]         = fifo_empty;
        status[ST_FULL]          = fifo_full;
        status[ST_BUSY]          = busy_q;
        status[ST_OVF]           = ovf_q;
        status[ST_CNT_LSB +: 3]  = cnt3;
    end

    assign tx    = tx_q;
    assign busy  = busy_q;
    assign full  = fifo_full;
    assign empty = fifo_empty;

endmodule

// File: tb/tb_io_serial_tx.sv
// Directed bench for io_serial_tx with a scoreboard fed by a serial-line monitor.
module tb_io_serial_tx;
    localparam int CPB = 4;
`ifdef IO_SERIAL_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] A5_BITS = 11'b10101001010;
`else
    localparam int NB = 10;
    localparam logic [10:0] A5_BITS = 11'b01101001010;
`endif
    localparam int FRAME = NB * CPB;

    logic       clk = 1'b0, reset = 1'b1, wr_stb = 1'b0, clr_ovf = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx, busy, full, empty;
    logic [7:0] status;

    int checks = 0, errors = 0;
    logic [7:0] sb[$];

    io_serial_tx #(.WIDTH(8), .DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .wr_stb(wr_stb), .wr_data(wr_data), .clr_ovf(clr_ovf),
        .tx(tx), .busy(busy), .full(full), .empty(empty), .status(status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read 1 ns after the rising edge.
    task automatic cyc(input logic stb, input logic [7:0] d, input logic clr, input logic rst);
        @(negedge clk);
        wr_stb = stb; wr_data = d; clr_ovf = clr; reset = rst;
        @(posedge clk); #1;
    endtask

    // Line monitor: decode each frame at mid-bit and compare with the scoreboard.
    initial begin
        logic [10:0] bits;
        logic        ab;
        logic [7:0]  got;
        forever begin
            @(posedge clk); #1;
            if (reset || tx !== 1'b0) continue;
            ab = 1'b0;
            bits = '0;
            for (int b = 0; b < NB && !ab; b++) begin
                for (int w = 0; w < ((b == 0) ? CPB / 2 : CPB); w++) begin
                    @(posedge clk); #1;
                    if (reset) ab = 1'b1;
                end
                bits[b] = tx;
            end
            if (ab) continue;
            got = bits[8:1];
            chk("mon_start", bits[0], 1'b0);
            chk("mon_stop", bits[NB-1], 1'b1);
`ifdef IO_SERIAL_TX_PARITY_EN
            chk("mon_parity", bits[9], ^got);
`endif
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon_unexpected got %0h want none", got);
            end else begin
                chk("mon_data", got, sb.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        // reset
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 0, 1);
        chk("rst_tx", tx, 1'b1);
        chk("rst_status", status, 8'h01);
        cyc(0, 8'h00, 0, 0);
        chk("rst_tx2", tx, 1'b1);
        chk("rst_status2", status, 8'h01);

        // single byte A5, checked bit by bit
        cyc(1, 8'hA5, 0, 0); sb.push_back(8'hA5);
        chk("a5_queued", status, 8'h10);
        for (int k = 0; k < FRAME; k++) begin
            cyc(0, 8'h00, 0, 0);
            chk($sformatf("a5_tx%0d", k), tx, A5_BITS[k / CPB]);
            chk($sformatf("a5_busy%0d", k), busy, 1'b1);
        end
        cyc(0, 8'h00, 0, 0);
        chk("a5_done", status, 8'h01);

        // back-to-back 00, FF
        cyc(1, 8'h00, 0, 0); sb.push_back(8'h00);
        chk("b2b_cnt_a", status[6:4], 3'd1);
        cyc(1, 8'hFF, 0, 0); sb.push_back(8'hFF);
        chk("b2b_cnt_b", status[6:4], 3'd1);
        chk("b2b_tx_a", tx, 1'b0);
        ok = 1'b1;
        for (int k = 1; k < FRAME; k++) begin
            cyc(0, 8'h00, 0, 0);
            if (busy !== 1'b1) ok = 1'b0;
        end
        cyc(0, 8'h00, 0, 0);
        chk("b2b_start2", tx, 1'b0);
        chk("b2b_cnt_c", status[6:4], 3'd0);
        for (int k = 1; k < FRAME; k++) begin
            cyc(0, 8'h00, 0, 0);
            if (busy !== 1'b1) ok = 1'b0;
        end
        chk("b2b_nogap", ok, 1'b1);
        cyc(0, 8'h00, 0, 0);
        chk("b2b_done", status, 8'h01);

        // overflow while a frame is in flight
        cyc(1, 8'h11, 0, 0); sb.push_back(8'h11);
        cyc(0, 8'h00, 0, 0);
        chk("ovf_popped", status, 8'h05);
        cyc(1, 8'h21, 0, 0); sb.push_back(8'h21);
        cyc(1, 8'h32, 0, 0); sb.push_back(8'h32);
        cyc(1, 8'h43, 0, 0); sb.push_back(8'h43);
        cyc(1, 8'h54, 0, 0); sb.push_back(8'h54);
        chk("ovf_full", status, 8'h46);
        cyc(1, 8'h65, 0, 0);
        chk("ovf_set", status, 8'h4E);
        cyc(1, 8'h76, 1, 0);
        chk("ovf_set_wins", status, 8'h4E);
        cyc(0, 8'h00, 1, 0);
        chk("ovf_clr", status, 8'h46);
        repeat (FRAME - 8) cyc(0, 8'h00, 0, 0);
        // this edge is the STOP-end pop of byte 11
        cyc(1, 8'h87, 0, 0); sb.push_back(8'h87);
        chk("popwr_status", status, 8'h46);
        chk("popwr_tx", tx, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            if (sb.size() == 0 && status == 8'h01) break;
            cyc(0, 8'h00, 0, 0);
        end
        chk("drain_sb", sb.size(), 0);
        chk("drain_status", status, 8'h01);

        // reset during data bit 3 with a second byte queued
        cyc(1, 8'hA5, 0, 0);
        cyc(1, 8'h3C, 0, 0);
        chk("mid_status", status, 8'h14);
        repeat (17) cyc(0, 8'h00, 0, 0);
        chk("mid_bit3", tx, A5_BITS[17 / CPB]);
        cyc(0, 8'h00, 0, 1);
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_status", status, 8'h01);
        ok = 1'b1;
        repeat (60) begin
            cyc(0, 8'h00, 0, 0);
            if (tx !== 1'b1 || status !== 8'h01) ok = 1'b0;
        end
        chk("mid_quiet", ok, 1'b1);
        chk("final_sb", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
